// File: rtl/proximity_pkg.sv
// Shared definitions for the trigger/echo proximity interface.
//   resp_state_t : responder FSM states
//   CNT_W        : width of the shared cycle counter and echo-width arithmetic
//   DIST_W       : width of a distance in cm
//   US_PER_CM    : round-trip echo time per cm in microseconds
//   echo_width() : echo-high width in cycles for a latched distance
package proximity_pkg;

    localparam int unsigned CNT_W     = 22;
    localparam int unsigned DIST_W    = 9;
    localparam int unsigned US_PER_CM = 58;

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HIGH,
        HOLDOFF,
        ECHO,
        RECOVER
    } resp_state_t;

    // Zero or beyond max_cm reads as "no object" and returns the timeout width.
    function automatic logic [CNT_W-1:0] echo_width(
        input logic [DIST_W-1:0] d,
        input logic [DIST_W-1:0] max_cm,
        input logic [CNT_W-1:0]  cyc_per_cm,
        input logic [CNT_W-1:0]  timeout
    );
        if (d == '0 || d > max_cm) begin
            return timeout;
        end
        return CNT_W'(d) * cyc_per_cm;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with registered edge outputs.
//   clk       : system clock
//   reset     : synchronous, active-high reset
//   async_in  : asynchronous input
//   level_out : synchronized level
//   rise_out  : high in the first cycle level_out is 1
//   fall_out  : high in the first cycle level_out is 0
// The edge flops sample the same pair the second stage does, so each pulse
// lines up with the cycle in which level_out changes.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level_out,
    output logic rise_out,
    output logic fall_out
);

    logic sync1_q, sync2_q, rise_q, fall_q;
    logic rise_d, fall_d;

    always_comb begin
        rise_d = sync1_q & ~sync2_q;
        fall_d = ~sync1_q & sync2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_out = sync2_q;
    assign rise_out  = rise_q;
    assign fall_out  = fall_q;

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04-style responder: answers a trigger pulse with an echo pulse whose
// width encodes distance_cm.
//   clk         : system clock
//   reset       : synchronous, active-high reset
//   enable      : when low, new triggers are ignored in IDLE
//   trig_in     : asynchronous trigger input
//   distance_cm : emulated target distance in cm
//   echo_out    : echo pulse
//   busy        : high whenever the FSM is not in IDLE
//   trig_reject : one-cycle pulse after a too-short trigger
//   meas_count  : number of echoes issued, wrapping at 8 bits
// HOLDOFF_CYCLES must be at least 3 so the registered width is ready before
// the echo starts.
module ultrasonic_echo_responder
    import proximity_pkg::*;
#(
    parameter int unsigned MIN_TRIG_CYCLES = 500,
    parameter int unsigned HOLDOFF_CYCLES  = 22500,
    parameter int unsigned CYCLES_PER_CM   = 2900,
    parameter int unsigned MAX_CM          = 400,
    parameter int unsigned TIMEOUT_CYCLES  = 1900000,
    parameter int unsigned RECOVERY_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              trig_in,
    input  logic [DIST_W-1:0] distance_cm,
    output logic              echo_out,
    output logic              busy,
    output logic              trig_reject,
    output logic [7:0]        meas_count
);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  TRIG_LOAD = CNT_W'(MIN_TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]  REC_LOAD  = CNT_W'(RECOVERY_CYCLES);
    localparam logic [CNT_W-1:0]  CPC       = CNT_W'(CYCLES_PER_CM);
    localparam logic [CNT_W-1:0]  TMO       = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [DIST_W-1:0] MAX_D     = DIST_W'(MAX_CM);

    logic trig_s, trig_rise, trig_fall;

    sync_edge_detect u_trig_sync (
        .clk       (clk),
        .reset     (reset),
        .async_in  (trig_in),
        .level_out (trig_s),
        .rise_out  (trig_rise),
        .fall_out  (trig_fall)
    );

    resp_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              echo_q, echo_d;
    logic              rej_q, rej_d;
    logic              arm_q, arm_d;
    logic [7:0]        mcount_q, mcount_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        width_d  = width_q;
        dist_d   = dist_q;
        echo_d   = echo_q;
        rej_d    = 1'b0;
        arm_d    = 1'b0;
        mcount_d = mcount_q;

        unique case (state_q)
            IDLE: begin
                // Arm only once the trigger has been seen low here, so a
                // trigger still held from the previous measurement is ignored.
                arm_d = arm_q | ~trig_s;
                if (trig_rise && arm_q && enable) begin
                    state_d = TRIG_HIGH;
                    // The rising-edge cycle already counts as one high cycle;
                    // the counter runs down to zero once the width is met.
                    cnt_d   = TRIG_LOAD;
                    arm_d   = 1'b0;
                end
            end
            TRIG_HIGH: begin
                if (trig_fall) begin
                    if (cnt_q == '0) begin
                        state_d = HOLDOFF;
                        cnt_d   = HOLD_LOAD;
                        dist_d  = distance_cm;
                    end else begin
                        state_d = IDLE;
                        rej_d   = 1'b1;
                    end
                end else if (trig_s && cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLDOFF: begin
                // Width is registered on the first holdoff cycle only.
                if (cnt_q == HOLD_LOAD) begin
                    width_d = echo_width(dist_q, MAX_D, CPC, TMO);
                end
                if (cnt_q <= CNT_ONE) begin
                    state_d  = ECHO;
                    echo_d   = 1'b1;
                    cnt_d    = width_q;
                    mcount_d = mcount_q + 8'd1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ECHO: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = RECOVER;
                    echo_d  = 1'b0;
                    cnt_d   = REC_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RECOVER: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                echo_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            width_q  <= '0;
            dist_q   <= '0;
            echo_q   <= 1'b0;
            rej_q    <= 1'b0;
            arm_q    <= 1'b0;
            mcount_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            dist_q   <= dist_d;
            echo_q   <= echo_d;
            rej_q    <= rej_d;
            arm_q    <= arm_d;
            mcount_q <= mcount_d;
        end
    end

    assign echo_out    = echo_q;
    assign busy        = (state_q != IDLE);
    assign trig_reject = rej_q;
    assign meas_count  = mcount_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Scoreboard bench for ultrasonic_echo_responder. Stimulus predicts each
// trigger's outcome from the interface rules and queues it; a negedge monitor
// measures echo/reject pulses and compares them against the queue.
module tb_ultrasonic_echo_responder;

    localparam int MIN_T = 10;
    localparam int HOLD  = 5;
    localparam int CPC   = 4;
    localparam int MAXC  = 400;
    localparam int TMO   = 2000;
    localparam int REC   = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       trig_in = 1'b0;
    logic [8:0] distance_cm = 9'd0;
    logic       echo_out, busy, trig_reject;
    logic [7:0] meas_count;

    ultrasonic_echo_responder #(
        .MIN_TRIG_CYCLES (MIN_T),
        .HOLDOFF_CYCLES  (HOLD),
        .CYCLES_PER_CM   (CPC),
        .MAX_CM          (MAXC),
        .TIMEOUT_CYCLES  (TMO),
        .RECOVERY_CYCLES (REC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .trig_in     (trig_in),
        .distance_cm (distance_cm),
        .echo_out    (echo_out),
        .busy        (busy),
        .trig_reject (trig_reject),
        .meas_count  (meas_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit is_echo;
        int at;      // cycle of echo rise or reject pulse
        int width;   // echo-high cycles
        int cnt;     // meas_count while echo is high
        int rec;     // busy cycles after echo falls
    } exp_t;

    exp_t exp_q[$];

    int   free_at = 0;   // first cycle the responder is expected idle again
    int   model_cnt = 0;
    int   last_rise = 0;
    logic last_busy_at_drop = 1'b0;

    function automatic int ref_width(input int d);
        if (d == 0 || d > MAXC) return TMO;
        return d * CPC;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // trig_in high for n cycles. The synchronized rise appears at s+2 and the
    // first synchronized-low cycle (T) at drop+2.
    task automatic pulse(input int n, input int d);
        int s, drop, w, rise;
        bit acc;
        step();
        distance_cm = 9'(d);
        trig_in = 1'b1;
        s = cyc;
        // Accepted only if idle and seen low for a cycle before the rise.
        acc = (enable == 1'b1) && (s + 1 >= free_at);
        repeat (n) @(posedge clk);
        #1;
        trig_in = 1'b0;
        drop = cyc;
        last_busy_at_drop = busy;
        if (acc) begin
            if (n < MIN_T) begin
                exp_q.push_back('{is_echo: 1'b0, at: drop + 3, width: 0, cnt: 0, rec: 0});
                free_at = drop + 3;
            end else begin
                rise = drop + 2 + HOLD;
                w = ref_width(d);
                model_cnt = (model_cnt + 1) % 256;
                exp_q.push_back('{is_echo: 1'b1, at: rise, width: w, cnt: model_cnt, rec: REC});
                free_at = rise + w + REC;
                last_rise = rise;
            end
        end
        repeat (3) step();
        // Distance is already latched; later changes must not matter.
        distance_cm = 9'($urandom_range(0, 511));
    endtask

    task automatic wait_idle(input int gap);
        while (cyc < free_at + gap) step();
        chk("idle_busy", busy, 0);
        chk("idle_echo", echo_out, 0);
    endtask

    // Monitor
    bit   in_echo = 1'b0;
    bit   in_rec = 1'b0;
    int   m_rise, m_width, m_cnt, m_rec;
    exp_t mon_e;

    always @(negedge clk) begin
        if (trig_reject === 1'b1) begin
            if (exp_q.size() == 0 || exp_q[0].is_echo) begin
                checks++;
                errors++;
                $display("FAIL unexpected_reject: got reject at cycle %0d, expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("reject_cycle", cyc, mon_e.at);
            end
        end
        if (echo_out === 1'b1) begin
            if (!in_echo) begin
                in_echo = 1'b1;
                m_rise  = cyc;
                m_width = 0;
                m_cnt   = int'(meas_count);
            end
            m_width++;
        end else if (in_echo) begin
            in_echo = 1'b0;
            in_rec  = 1'b1;
            m_rec   = 0;
        end
        if (in_rec) begin
            if (busy === 1'b1) begin
                m_rec++;
            end else begin
                in_rec = 1'b0;
                if (exp_q.size() == 0 || !exp_q[0].is_echo) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_echo: got echo rising at cycle %0d, expected none",
                             m_rise);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("echo_rise_cycle", m_rise, mon_e.at);
                    chk("echo_width", m_width, mon_e.width);
                    chk("echo_meas_count", m_cnt, mon_e.cnt);
                    chk("recover_busy_cycles", m_rec, mon_e.rec);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish by cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e2;
        int   n, d, r;

        // Reset state
        reset = 1'b1;
        repeat (4) step();
        chk("reset_echo", echo_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_reject", trig_reject, 0);
        chk("reset_count", meas_count, 0);
        reset = 1'b0;
        free_at = cyc + 1;
        wait_idle(3);

        // Nominal
        pulse(12, 25);
        chk("nominal_busy_at_drop", last_busy_at_drop, 1);
        wait_idle(5);
        chk("nominal_count", meas_count, model_cnt);

        // Short trigger
        pulse(6, 25);
        chk("short_busy_at_drop", last_busy_at_drop, 1);
        wait_idle(5);
        chk("short_count", meas_count, model_cnt);

        // Out of range and max range
        pulse(11, 0);
        wait_idle(5);
        pulse(11, 401);
        wait_idle(5);
        pulse(11, 400);
        wait_idle(5);

        // Lockout: retrigger during ECHO, during RECOVER, held across IDLE entry
        pulse(12, 25);
        repeat (20) step();
        pulse(12, 30);
        while (cyc < free_at - 18) step();
        pulse(10, 50);
        pulse(20, 60);
        wait_idle(3);
        pulse(12, 10);
        wait_idle(3);

        // Reset 30 cycles into a 100-cycle echo
        pulse(12, 25);
        while (cyc < last_rise + 29) step();
        reset = 1'b1;
        if (exp_q.size() > 0) begin
            e2 = exp_q.pop_back();
            e2.width = cyc - last_rise + 1;
            e2.rec = 0;
            exp_q.push_back(e2);
        end
        model_cnt = 0;
        step();
        chk("midreset_echo", echo_out, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_count", meas_count, model_cnt);
        chk("midreset_reject", trig_reject, 0);
        repeat (2) step();
        reset = 1'b0;
        free_at = cyc + 2;
        wait_idle(3);
        pulse(12, 25);
        wait_idle(3);

        // Wrap: 255 more echoes bring the count to 256 -> 0
        for (int i = 0; i < 255; i++) begin
            pulse(10, int'($urandom_range(1, 5)));
            wait_idle(int'($urandom_range(1, 4)));
        end
        chk("wrap_count", meas_count, model_cnt);

        // Disabled in IDLE
        enable = 1'b0;
        pulse(12, 25);
        chk("disabled_busy_at_drop", last_busy_at_drop, 0);
        wait_idle(5);
        enable = 1'b1;

        // Randomized triggers, distances and occasional lockout retriggers
        for (int i = 0; i < 12; i++) begin
            n = int'($urandom_range(4, 16));
            r = int'($urandom_range(0, 9));
            if (r == 0) d = 0;
            else if (r == 1) d = int'($urandom_range(401, 511));
            else d = int'($urandom_range(1, 400));
            pulse(n, d);
            if ($urandom_range(0, 3) == 0) begin
                pulse(int'($urandom_range(10, 14)), 7);
            end
            wait_idle(int'($urandom_range(1, 30)));
        end

        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) step();
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
